// File: rtl/bs2pol_unpack_generic.sv
// bs2pol_unpack_generic
//
// Unpacks a stream of COEF_W-bit coefficients, packed LSB-first across
// consecutive 64-bit source RAM words, into destination RAM words that hold
// four coefficients each, one per 16-bit lane ({lane3,lane2,lane1,lane0}).
// Used for p-, q- and T-domain polynomial vectors. Base addresses and the
// source word count are programmable at run time and latched on start.
//
// Parameters
//   COEF_W         coefficient width in bits, 1..16
//   ADDR_W         source/destination address width
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   start          one-cycle pulse, accepted only in IDLE or DONE
//   rd_base        first source word address (latched on start)
//   wr_base        first destination word address (latched on start)
//   n_words        number of 64-bit source words to consume (latched on start)
//   sign_ext       only with SIGN_EXT_EN: sign-extend lanes (latched on start)
//   read_address   source RAM address; data returns one cycle later
//   read_data      source RAM data
//   write_address  destination RAM address
//   write_data     four 16-bit lanes
//   write_en       destination write strobe
//   busy           high while fetching/unpacking
//   done           high once a job has finished, until the next start or rst
//
// Build option
//   SIGN_EXT_EN    adds the sign_ext port; without it lanes are always
//                  zero-extended.

module bs2pol_unpack_generic #(
    parameter int COEF_W = 10,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [ADDR_W-1:0] n_words,
`ifdef SIGN_EXT_EN
    input  logic              sign_ext,
`endif
    output logic [ADDR_W-1:0] read_address,
    input  logic [63:0]       read_data,
    output logic [ADDR_W-1:0] write_address,
    output logic [63:0]       write_data,
    output logic              write_en,
    output logic              busy,
    output logic              done
);

    // One destination word consumes four coefficients from the accumulator.
    localparam int              GROUP_W    = 4 * COEF_W;
    localparam logic [7:0]      GROUP_FILL = 8'(GROUP_W);
    localparam logic [15:0]     LANE_MASK  = 16'((17'd1 << COEF_W) - 17'd1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   rdAddr_q,   rdAddr_d;
    logic [ADDR_W-1:0]   wrAddr_q,   wrAddr_d;
    logic [ADDR_W-1:0]   nWords_q,   nWords_d;
    logic [ADDR_W-1:0]   issued_q,   issued_d;
    logic [ADDR_W-1:0]   absorbed_q, absorbed_d;
    logic                pending_q,  pending_d;
    logic [127:0]        buf_q,      buf_d;
    logic [7:0]          fill_q,     fill_d;
`ifdef SIGN_EXT_EN
    logic                signExt_q,  signExt_d;
`endif

    logic                doWrite;
    logic                doIssue;
    logic [7:0]          consume;
    logic [7:0]          fillAfterConsume;
    logic [127:0]        shifted;
    logic [127:0]        appended;

    // A write drains the low GROUP_W bits; incoming read data is appended
    // above whatever survives this cycle's drain, so an absorb and a write
    // in the same cycle neither lose nor duplicate bits. A new read is only
    // launched when the bits left after this cycle's drain leave room for a
    // full 64-bit append next cycle, which keeps the 128-bit buffer from
    // ever overflowing.
    always_comb begin
        doWrite          = (state_q == FETCH) && (fill_q >= GROUP_FILL);
        consume          = doWrite ? GROUP_FILL : 8'd0;
        fillAfterConsume = fill_q - consume;
        doIssue          = (state_q == FETCH) && (issued_q < nWords_q) &&
                           !pending_q && (fillAfterConsume <= 8'd64);
        shifted          = doWrite ? (buf_q >> GROUP_W) : buf_q;
        appended         = {64'd0, read_data} << fillAfterConsume;
    end

    always_comb begin
        state_d    = state_q;
        rdAddr_d   = rdAddr_q;
        wrAddr_d   = wrAddr_q;
        nWords_d   = nWords_q;
        issued_d   = issued_q;
        absorbed_d = absorbed_q;
        pending_d  = doIssue;
        buf_d      = buf_q;
        fill_d     = fill_q;
`ifdef SIGN_EXT_EN
        signExt_d  = signExt_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = FETCH;
                    rdAddr_d   = rd_base;
                    wrAddr_d   = wr_base;
                    nWords_d   = n_words;
                    issued_d   = '0;
                    absorbed_d = '0;
                    pending_d  = 1'b0;
                    buf_d      = '0;
                    fill_d     = '0;
`ifdef SIGN_EXT_EN
                    signExt_d  = sign_ext;
`endif
                end
            end

            FETCH: begin
                // pending_q marks the cycle in which the previous read's data
                // is on read_data.
                if (pending_q) begin
                    buf_d      = shifted | appended;
                    fill_d     = fillAfterConsume + 8'd64;
                    absorbed_d = absorbed_q + 1'b1;
                end else begin
                    buf_d      = shifted;
                    fill_d     = fillAfterConsume;
                end

                if (doWrite) begin
                    wrAddr_d = wrAddr_q + 1'b1;
                end

                if (doIssue) begin
                    rdAddr_d = rdAddr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                end

                // Every read absorbed and too few bits left for another
                // destination word: the remainder is dropped.
                if ((absorbed_q == nWords_q) && (fill_q < GROUP_FILL)) begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rdAddr_q   <= '0;
            wrAddr_q   <= '0;
            nWords_q   <= '0;
            issued_q   <= '0;
            absorbed_q <= '0;
            pending_q  <= 1'b0;
            buf_q      <= '0;
            fill_q     <= '0;
`ifdef SIGN_EXT_EN
            signExt_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rdAddr_q   <= rdAddr_d;
            wrAddr_q   <= wrAddr_d;
            nWords_q   <= nWords_d;
            issued_q   <= issued_d;
            absorbed_q <= absorbed_d;
            pending_q  <= pending_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
`ifdef SIGN_EXT_EN
            signExt_q  <= signExt_d;
`endif
        end
    end

    // Lane k carries coefficient k of the current group, widened to 16 bits.
    always_comb begin
        write_data = '0;
        for (int k = 0; k < 4; k++) begin
            logic [COEF_W-1:0] coef;
            logic [15:0]       lane;
            coef = buf_q[k*COEF_W +: COEF_W];
            lane = 16'(coef);
`ifdef SIGN_EXT_EN
            if (signExt_q && coef[COEF_W-1]) begin
                lane = lane | ~LANE_MASK;
            end
`endif
            write_data[k*16 +: 16] = lane;
        end
    end

    assign write_en      = doWrite;
    assign read_address  = rdAddr_q;
    assign write_address = wrAddr_q;
    assign busy          = (state_q == FETCH);
    assign done          = (state_q == DONE);

`ifndef SIGN_EXT_EN
    // The mask only matters when sign extension is built in.
    logic unusedMask;
    assign unusedMask = ^LANE_MASK;
`endif

endmodule
